fork_join_sync: RTL and testbench

FORK_JOIN_SYNC -- requirements
Module: fork_join_sync

---
 rtl/fork_join_pkg.sv | 30 +++
 rtl/fork_join_delay.sv | 36 +++
 rtl/fork_join_sync.sv | 128 ++++++++++++
 tb/tb_fork_join_sync.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join synchroniser.
//   state_e     : controller states (IDLE, LAUNCH, WAIT, DELAY, DRAIN)
//   join_mode_e : join policy latched at fork acceptance
//   decode_mode : maps the raw 2-bit join_mode input onto join_mode_e
package fork_join_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DELAY  = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'b00,
    JOIN_ANY  = 2'b01,
    JOIN_NONE = 2'b10
  } join_mode_e;

  // Encoding 11 is reserved and behaves like a full join.
  function automatic join_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   decode_mode = JOIN_ANY;
      2'b10:   decode_mode = JOIN_NONE;
      default: decode_mode = JOIN_ALL;
    endcase
  endfunction

endpackage

// File: rtl/fork_join_delay.sv
// Post-join delay counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : load dly_i into the counter
//   dly_i      : delay value (cycles)
//   run_i      : count down while high
//   expire_o   : high in the run cycle where the count has reached zero
module fork_join_delay #(
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DLY_W-1:0] dly_i,
  input  logic             run_i,
  output logic             expire_o
);

  logic [DLY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = dly_i;
    else if (run_i && (cnt_q != '0))
      cnt_d = cnt_q - {{(DLY_W-1){1'b0}}, 1'b1};
  end

  // A load value of N therefore expires in the (N+1)-th run cycle.
  assign expire_o = run_i && !load_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fork_join_sync.sv
// Fork/join synchroniser: launches NPROC workers, waits on the selected join
// policy, then emits a continuation event after a programmable delay.
//   clk, rst_n : clock, asynchronous active-low reset
//   fork_req   : launch request (level, honoured only in IDLE)
//   join_mode  : 00 all, 01 any, 10 none, 11 as 00
//   delay      : cycles from join_done to cont_evt minus one
//   fork_ack   : pulse, request accepted
//   proc_start : pulse on all worker bits together
//   proc_done  : worker completion pulses
//   join_done  : pulse, join condition met
//   cont_evt   : pulse, continuation event
//   busy       : state != IDLE
module fork_join_sync
  import fork_join_pkg::*;
#(
  parameter int NPROC = 2,
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fork_req,
  input  logic [1:0]       join_mode,
  input  logic [DLY_W-1:0] delay,
  output logic             fork_ack,
  output logic [NPROC-1:0] proc_start,
  input  logic [NPROC-1:0] proc_done,
  output logic             join_done,
  output logic             cont_evt,
  output logic             busy
);

  state_e           state_q, state_d;
  join_mode_e       mode_q, mode_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [NPROC-1:0] pend_q, pend_d;
  logic             join_done_q, join_done_d;
  logic             cont_evt_q, cont_evt_d;

  logic [NPROC-1:0] cleared, pend_after;
  logic             dly_load, dly_expire;

  assign cleared    = pend_q & proc_done;
  assign pend_after = pend_q & ~proc_done;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    dly_d       = dly_q;
    pend_d      = pend_q;
    join_done_d = 1'b0;
    cont_evt_d  = 1'b0;
    dly_load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fork_req) begin
          mode_d  = decode_mode(join_mode);
          dly_d   = delay;
          state_d = ST_LAUNCH;
        end
      end
      // proc_done is deliberately not looked at here: workers only start now.
      ST_LAUNCH: begin
        pend_d = '1;
        if (mode_q == JOIN_NONE) begin
          join_done_d = 1'b1;
          dly_load    = 1'b1;
          state_d     = ST_DELAY;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        pend_d = pend_after;
        if ((mode_q == JOIN_ANY) ? (|cleared) : (pend_after == '0)) begin
          join_done_d = 1'b1;
          dly_load    = 1'b1;
          state_d     = ST_DELAY;
        end
      end
      ST_DELAY: begin
        pend_d = pend_after;
        if (dly_expire) begin
          cont_evt_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pend_d = pend_after;
        if (pend_after == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= JOIN_ALL;
      dly_q       <= '0;
      pend_q      <= '0;
      join_done_q <= 1'b0;
      cont_evt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      dly_q       <= dly_d;
      pend_q      <= pend_d;
      join_done_q <= join_done_d;
      cont_evt_q  <= cont_evt_d;
    end
  end

  fork_join_delay #(.DLY_W(DLY_W)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (dly_load),
    .dly_i    (dly_q),
    .run_i    (state_q == ST_DELAY),
    .expire_o (dly_expire)
  );

  assign fork_ack   = (state_q == ST_LAUNCH);
  assign proc_start = {NPROC{state_q == ST_LAUNCH}};
  assign join_done  = join_done_q;
  assign cont_evt   = cont_evt_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fork_join_sync.sv
module tb_fork_join_sync;

  localparam int NPROC = 2;
  localparam int DLY_W = 8;

  // Observed output bundle: {fork_ack, proc_start[1:0], join_done, cont_evt, busy}
  localparam logic [5:0] Z = 6'b000000;  // idle, nothing
  localparam logic [5:0] L = 6'b111001;  // launch cycle
  localparam logic [5:0] B = 6'b000001;  // busy only
  localparam logic [5:0] J = 6'b000101;  // join_done pulse
  localparam logic [5:0] C = 6'b000011;  // cont_evt pulse

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fork_req = 1'b0;
  logic [1:0]       join_mode = 2'b00;
  logic [DLY_W-1:0] delay = '0;
  logic             fork_ack;
  logic [NPROC-1:0] proc_start;
  logic [NPROC-1:0] proc_done = '0;
  logic             join_done;
  logic             cont_evt;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic             req;
    logic [1:0]       mode;
    logic [DLY_W-1:0] dly;
    logic [NPROC-1:0] done;
    logic [5:0]       exp;
  } row_t;

  row_t tbl[$];
  row_t rst_pre[$];
  row_t rst_post[$];

  fork_join_sync #(.NPROC(NPROC), .DLY_W(DLY_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fork_req   (fork_req),
    .join_mode  (join_mode),
    .delay      (delay),
    .fork_ack   (fork_ack),
    .proc_start (proc_start),
    .proc_done  (proc_done),
    .join_done  (join_done),
    .cont_evt   (cont_evt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input logic r, input logic [1:0] m, input logic [DLY_W-1:0] d,
                              input logic [NPROC-1:0] dn, input logic [5:0] e);
    row_t x;
    x.req = r; x.mode = m; x.dly = d; x.done = dn; x.exp = e;
    return x;
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {fork_ack, proc_start, join_done, cont_evt, busy};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ack/start/jd/ce/busy=%b expected %b", name, act, exp);
    end
  endtask

  // Inputs for a cycle are driven just after the falling edge; outputs reflect
  // the current state only, so they are checked in the same half-cycle.
  task automatic apply(input row_t r, input string name);
    @(negedge clk);
    fork_req  = r.req;
    join_mode = r.mode;
    delay     = r.dly;
    proc_done = r.done;
    #1 check(name, r.exp);
  endtask

  initial begin
    // join_any, delay=1, done=01 three cycles after start; mode/delay changed after accept
    tbl.push_back(mk(1'b1, 2'b01, 8'd1, 2'b00, Z));
    tbl.push_back(mk(1'b0, 2'b00, 8'd7, 2'b00, L));
    tbl.push_back(mk(1'b0, 2'b00, 8'd7, 2'b00, B));
    tbl.push_back(mk(1'b0, 2'b00, 8'd7, 2'b00, B));
    tbl.push_back(mk(1'b0, 2'b00, 8'd7, 2'b01, B));
    tbl.push_back(mk(1'b0, 2'b00, 8'd7, 2'b00, J));
    tbl.push_back(mk(1'b0, 2'b00, 8'd7, 2'b00, B));
    tbl.push_back(mk(1'b0, 2'b00, 8'd7, 2'b00, C));
    tbl.push_back(mk(1'b0, 2'b00, 8'd7, 2'b10, B));
    // join_all, delay=0; done during LAUNCH ignored, repeated done ignored
    tbl.push_back(mk(1'b1, 2'b00, 8'd0, 2'b00, Z));
    tbl.push_back(mk(1'b0, 2'b01, 8'd5, 2'b11, L));
    tbl.push_back(mk(1'b0, 2'b01, 8'd5, 2'b01, B));
    tbl.push_back(mk(1'b0, 2'b01, 8'd5, 2'b01, B));
    tbl.push_back(mk(1'b0, 2'b01, 8'd5, 2'b00, B));
    tbl.push_back(mk(1'b0, 2'b01, 8'd5, 2'b10, B));
    tbl.push_back(mk(1'b0, 2'b01, 8'd5, 2'b00, J));
    tbl.push_back(mk(1'b0, 2'b01, 8'd5, 2'b00, C));
    // join_none, delay=3, fork_req held high through the group
    tbl.push_back(mk(1'b1, 2'b10, 8'd3, 2'b00, Z));
    tbl.push_back(mk(1'b1, 2'b10, 8'd3, 2'b00, L));
    tbl.push_back(mk(1'b1, 2'b10, 8'd3, 2'b11, J));
    tbl.push_back(mk(1'b1, 2'b10, 8'd3, 2'b00, B));
    tbl.push_back(mk(1'b1, 2'b10, 8'd3, 2'b00, B));
    tbl.push_back(mk(1'b1, 2'b10, 8'd3, 2'b00, B));
    tbl.push_back(mk(1'b1, 2'b11, 8'd0, 2'b00, C));
    // second group from IDLE with mode 11 (behaves as join_all)
    tbl.push_back(mk(1'b1, 2'b11, 8'd0, 2'b00, Z));
    tbl.push_back(mk(1'b1, 2'b00, 8'd0, 2'b00, L));
    tbl.push_back(mk(1'b1, 2'b01, 8'd0, 2'b01, B));
    tbl.push_back(mk(1'b1, 2'b01, 8'd0, 2'b10, B));
    tbl.push_back(mk(1'b1, 2'b01, 8'd0, 2'b00, J));
    tbl.push_back(mk(1'b0, 2'b01, 8'd0, 2'b00, C));
    // join_any with simultaneous done=11
    tbl.push_back(mk(1'b1, 2'b01, 8'd0, 2'b00, Z));
    tbl.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, L));
    tbl.push_back(mk(1'b0, 2'b00, 8'd0, 2'b11, B));
    tbl.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, J));
    tbl.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, C));
    tbl.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, Z));
    tbl.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, Z));

    // group interrupted by reset while in DELAY (delay=5)
    rst_pre.push_back(mk(1'b1, 2'b00, 8'd5, 2'b00, Z));
    rst_pre.push_back(mk(1'b0, 2'b00, 8'd5, 2'b00, L));
    rst_pre.push_back(mk(1'b0, 2'b00, 8'd5, 2'b11, B));
    rst_pre.push_back(mk(1'b0, 2'b00, 8'd5, 2'b00, J));
    rst_pre.push_back(mk(1'b0, 2'b00, 8'd5, 2'b00, B));

    // after release: quiet window past the aborted cont_evt, then a fresh join_any group
    for (int i = 0; i < 8; i++) rst_post.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, Z));
    rst_post.push_back(mk(1'b1, 2'b01, 8'd0, 2'b00, Z));
    rst_post.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, L));
    rst_post.push_back(mk(1'b0, 2'b00, 8'd0, 2'b01, B));
    rst_post.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, J));
    rst_post.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, C));
    rst_post.push_back(mk(1'b0, 2'b00, 8'd0, 2'b10, B));
    rst_post.push_back(mk(1'b0, 2'b00, 8'd0, 2'b00, Z));

    // Reset held with a request pending: outputs stay quiet
    fork_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", Z);
    @(negedge clk);
    fork_req = 1'b0;
    rst_n    = 1'b1;
    #1 check("reset_release", Z);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    for (int i = 0; i < rst_pre.size(); i++) apply(rst_pre[i], $sformatf("rst_pre[%0d]", i));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", Z);
    apply(mk(1'b1, 2'b00, 8'd0, 2'b11, Z), "rst_low[0]");
    apply(mk(1'b1, 2'b00, 8'd0, 2'b00, Z), "rst_low[1]");
    @(negedge clk);
    fork_req = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < rst_post.size(); i++) apply(rst_post[i], $sformatf("rst_post[%0d]", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
